// File: rtl/switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_box_cfg
//  Description : Routing switch box joining the l/r/t/b track bundles of one
//                fabric tile. A serial prog chain loads the 2-bit per-track
//                selects. The new config takes effect only when the load had
//                the exact length and contains no straight mutual drive.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_box_cfg #(
    parameter int WIDTH   = 10,
    parameter int PATTERN = 0
) (
    input  logic             prog_clk,
    input  logic             prog_rst,
    input  logic             prog_in,
    input  logic             prog_en,
    inout  wire  [WIDTH-1:0] l,
    inout  wire  [WIDTH-1:0] r,
    inout  wire  [WIDTH-1:0] t,
    inout  wire  [WIDTH-1:0] b,
    output logic             prog_out,
    output logic             cfg_valid,
    output logic             cfg_err
);

    localparam int NUM_BITS = WIDTH * 8;
    localparam int c_CNT_W  = $clog2(NUM_BITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(NUM_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(NUM_BITS + 1);
    localparam int c_OFS_L  = 0;
    localparam int c_OFS_T  = 2 * WIDTH;
    localparam int c_OFS_R  = 4 * WIDTH;
    localparam int c_OFS_B  = 6 * WIDTH;

    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_control;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_prog_en_q;
    logic                r_cfg_valid;
    logic                r_cfg_err;
    logic                w_loop;
    logic                w_fall;
    logic                w_commit;

    // Flag a candidate config in which a track pair drives itself straight across.
    always_comb begin
        w_loop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((r_shift[c_OFS_L + 2*i +: 2] == 2'd1 && r_shift[c_OFS_R + 2*i +: 2] == 2'd3) ||
                (r_shift[c_OFS_T + 2*i +: 2] == 2'd1 && r_shift[c_OFS_B + 2*i +: 2] == 2'd3)) begin
                w_loop = 1'b1;
            end
        end
    end

    assign w_fall   = r_prog_en_q & ~prog_en;
    assign w_commit = (r_cnt == c_CNT_FULL) && !w_loop;

    // Serial shift, bit counting and end-of-load commit/reject.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            r_shift     <= '0;
            r_control   <= '0;
            r_cnt       <= '0;
            r_prog_en_q <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_prog_en_q <= prog_en;
            if (prog_en) begin
                r_shift <= {r_shift[NUM_BITS-2:0], prog_in};
                if (r_cnt != c_CNT_SAT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_fall) begin
                // The shift register is left untouched so the chain to the next tile survives.
                r_cnt <= '0;
                if (w_commit) begin
                    r_control   <= r_shift;
                    r_cfg_valid <= 1'b1;
                    r_cfg_err   <= 1'b0;
                end else begin
                    r_cfg_err   <= 1'b1;
                end
            end
        end
    end

    assign prog_out  = r_shift[NUM_BITS-1];
    assign cfg_valid = r_cfg_valid;
    assign cfg_err   = r_cfg_err;

    // Per-track drivers. c_CW/c_CCW are the source indices used for turns that
    // come from the clockwise / counter-clockwise neighbour side.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_track
        localparam int c_CW  = (PATTERN != 0) ? ((gi + 1) % WIDTH) : gi;
        localparam int c_CCW = (PATTERN != 0) ? ((gi + WIDTH - 1) % WIDTH) : gi;

        logic [1:0] w_sel_l;
        logic [1:0] w_sel_t;
        logic [1:0] w_sel_r;
        logic [1:0] w_sel_b;
        logic       w_drv_l;
        logic       w_drv_t;
        logic       w_drv_r;
        logic       w_drv_b;

        assign w_sel_l = r_control[c_OFS_L + 2*gi +: 2];
        assign w_sel_t = r_control[c_OFS_T + 2*gi +: 2];
        assign w_sel_r = r_control[c_OFS_R + 2*gi +: 2];
        assign w_sel_b = r_control[c_OFS_B + 2*gi +: 2];

        assign w_drv_l = (w_sel_l == 2'd1) ? r[gi] : (w_sel_l == 2'd2) ? t[c_CW]  : b[c_CCW];
        assign w_drv_t = (w_sel_t == 2'd1) ? b[gi] : (w_sel_t == 2'd2) ? l[c_CCW] : r[c_CW];
        assign w_drv_r = (w_sel_r == 2'd1) ? t[c_CCW] : (w_sel_r == 2'd2) ? b[c_CW] : l[gi];
        assign w_drv_b = (w_sel_b == 2'd1) ? l[c_CW] : (w_sel_b == 2'd2) ? r[c_CCW] : t[gi];

        assign l[gi] = (w_sel_l == 2'd0) ? 1'bz : w_drv_l;
        assign t[gi] = (w_sel_t == 2'd0) ? 1'bz : w_drv_t;
        assign r[gi] = (w_sel_r == 2'd0) ? 1'bz : w_drv_r;
        assign b[gi] = (w_sel_b == 2'd0) ? 1'bz : w_drv_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_box_cfg
//  Description : Bench for switch_box_cfg with one disjoint and one Wilton
//                instance fed from the same prog stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_box_cfg;

    localparam int W = 10;
    localparam int N = W * 8;

    logic clk = 1'b0;
    logic prog_rst, prog_in, prog_en;
    wire  [W-1:0] l0, t0, r0, b0, l1, t1, r1, b1;
    logic prog_out0, cfg_valid0, cfg_err0;
    logic prog_out1, cfg_valid1, cfg_err1;

    // Bench-side track drivers; side index 0=l 1=t 2=r 3=b (clockwise order).
    logic [W-1:0] drv_val [4];
    logic [W-1:0] drv_en  [4];

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    bit hist[$];
    int load_bits;
    bit en_q, m_valid, m_err;
    int msel [4][W];
    int cfg  [4][W];

    always #5 clk = ~clk;

    switch_box_cfg #(.WIDTH(W), .PATTERN(0)) dut0 (
        .prog_clk(clk), .prog_rst(prog_rst), .prog_in(prog_in), .prog_en(prog_en),
        .l(l0), .r(r0), .t(t0), .b(b0),
        .prog_out(prog_out0), .cfg_valid(cfg_valid0), .cfg_err(cfg_err0)
    );

    switch_box_cfg #(.WIDTH(W), .PATTERN(1)) dut1 (
        .prog_clk(clk), .prog_rst(prog_rst), .prog_in(prog_in), .prog_en(prog_en),
        .l(l1), .r(r1), .t(t1), .b(b1),
        .prog_out(prog_out1), .cfg_valid(cfg_valid1), .cfg_err(cfg_err1)
    );

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign l0[i] = drv_en[0][i] ? drv_val[0][i] : 1'bz;
        assign t0[i] = drv_en[1][i] ? drv_val[1][i] : 1'bz;
        assign r0[i] = drv_en[2][i] ? drv_val[2][i] : 1'bz;
        assign b0[i] = drv_en[3][i] ? drv_val[3][i] : 1'bz;
        assign l1[i] = drv_en[0][i] ? drv_val[0][i] : 1'bz;
        assign t1[i] = drv_en[1][i] ? drv_val[1][i] : 1'bz;
        assign r1[i] = drv_en[2][i] ? drv_val[2][i] : 1'bz;
        assign b1[i] = drv_en[3][i] ? drv_val[3][i] : 1'bz;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Source side for a destination side and a nonzero select code.
    function automatic int src_side(int d, int sel);
        int tbl [4][3] = '{'{2, 1, 3}, '{3, 0, 2}, '{1, 3, 0}, '{0, 2, 1}};
        return tbl[d][sel-1];
    endfunction

    // Source index: straight keeps i; Wilton turns rotate by +1/-1.
    function automatic int src_idx(int d, int s, int i, int pattern);
        if (pattern != 0 && s == (d + 1) % 4) return (i + 1) % W;
        if (pattern != 0 && s == (d + 3) % 4) return (i + W - 1) % W;
        return i;
    endfunction

    // Select of side s track i inside the newest N bits of history.
    function automatic int hist_sel(int s, int i);
        int j = s * 2 * W + 2 * i;
        return 2 * int'(hist[N-1-(j+1)]) + int'(hist[N-1-j]);
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit din);
        bit loop;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < N; k++) hist.push_back(1'b0);
            load_bits = 0; en_q = 0; m_valid = 0; m_err = 0;
            for (int s = 0; s < 4; s++) for (int i = 0; i < W; i++) msel[s][i] = 0;
        end else begin
            if (en) begin
                hist.push_back(din);
                void'(hist.pop_front());
                load_bits++;
            end else if (en_q) begin
                loop = 0;
                for (int i = 0; i < W; i++)
                    if ((hist_sel(0, i) == 1 && hist_sel(2, i) == 3) ||
                        (hist_sel(1, i) == 1 && hist_sel(3, i) == 3)) loop = 1;
                if (load_bits == N && !loop) begin
                    for (int s = 0; s < 4; s++) for (int i = 0; i < W; i++) msel[s][i] = hist_sel(s, i);
                    m_valid = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
                load_bits = 0;
            end
            en_q = en;
        end
    endtask

    task automatic tick();
        model_step(prog_rst, prog_en, prog_in);
        @(posedge clk);
        @(negedge clk);
        chk("prog_out0", 64'(prog_out0), 64'(hist[0]));
        chk("prog_out1", 64'(prog_out1), 64'(hist[0]));
        chk("cfg_valid", 64'({cfg_valid0, cfg_valid1}), 64'({m_valid, m_valid}));
        chk("cfg_err",   64'({cfg_err0, cfg_err1}),     64'({m_err, m_err}));
        for (int s = 0; s < 4; s++) for (int i = 0; i < W; i++) drv_en[s][i] = (msel[s][i] == 0);
    endtask

    function automatic logic [W-1:0] net_of(int dut, int d);
        case ({dut[0], d[1:0]})
            3'b000: return l0;
            3'b001: return t0;
            3'b010: return r0;
            3'b011: return b0;
            3'b100: return l1;
            3'b101: return t1;
            3'b110: return r1;
            default: return b1;
        endcase
    endfunction

    task automatic check_tracks(input string tag);
        logic [W-1:0] exp;
        int s;
        for (int d = 0; d < 4; d++) drv_val[d] = W'($urandom);
        #1;
        for (int dut = 0; dut < 2; dut++) begin
            for (int d = 0; d < 4; d++) begin
                for (int i = 0; i < W; i++) begin
                    if (msel[d][i] == 0) exp[i] = drv_val[d][i];
                    else begin
                        s = src_side(d, msel[d][i]);
                        exp[i] = drv_val[s][src_idx(d, s, i, dut)];
                    end
                end
                chk($sformatf("%s dut%0d side%0d", tag, dut, d), 64'(net_of(dut, d)), 64'(exp));
            end
        end
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < 4; s++) for (int i = 0; i < W; i++) cfg[s][i] = 0;
    endtask

    // Random selects on one destination side only, so every source is bench-driven.
    task automatic rand_cfg(input int side);
        clear_cfg();
        for (int i = 0; i < W; i++) cfg[side][i] = int'($urandom_range(0, 3));
    endtask

    // Shift nbits (first bit ends at the MSB), then drop prog_en for the end-of-load edge.
    task automatic load(input int nbits);
        logic [N-1:0] word;
        for (int s = 0; s < 4; s++) for (int i = 0; i < W; i++) word[s*2*W + 2*i +: 2] = 2'(cfg[s][i]);
        for (int k = 0; k < nbits; k++) begin
            prog_en = 1'b1;
            prog_in = (k < N) ? word[N-1-k] : 1'($urandom);
            tick();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
        tick();
    endtask

    initial begin
        int kind;
        for (int d = 0; d < 4; d++) begin drv_val[d] = '0; drv_en[d] = '1; end

        // 1: reset with prog_en high
        prog_rst = 1'b1; prog_en = 1'b1; prog_in = 1'b1;
        tick(); tick();
        prog_rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0;
        check_tracks("reset");
        tick();

        // 2: only l[0] sel=1
        clear_cfg(); cfg[0][0] = 1;
        load(N);
        check_tracks("l0_from_r0");

        // 3: short and long loads are rejected, config kept
        rand_cfg(1); load(N - 1);
        check_tracks("short_load");
        rand_cfg(3); load(N + 1);
        check_tracks("long_load");

        // 4: straight mutual drive rejected, then a valid reload clears the error
        clear_cfg(); cfg[0][3] = 1; cfg[2][3] = 3;
        load(N);
        check_tracks("loop_reject");
        rand_cfg(2); load(N);
        check_tracks("reload");

        // 5: Wilton wrap-around turns
        clear_cfg(); cfg[0][9] = 2; cfg[0][0] = 3;
        load(N);
        check_tracks("wilton_wrap");

        // Randomised loads over all sides, lengths and loop injections
        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 5));
            rand_cfg(int'($urandom_range(0, 3)));
            if (kind == 0) load(N - 1);
            else if (kind == 1) begin
                clear_cfg(); cfg[1][n % W] = 1; cfg[3][n % W] = 3;
                load(N);
            end else load(N);
            check_tracks($sformatf("rand%0d", n));
        end

        // 6: chain echo of 1,0,1,1..., then reset mid-shift and a full load
        for (int k = 0; k < 2 * N; k++) begin
            prog_en = 1'b1; prog_in = (k % 4 != 1); tick();
        end
        prog_en = 1'b0; tick();
        for (int k = 0; k < 40; k++) begin
            prog_en = 1'b1; prog_in = 1'($urandom); tick();
        end
        prog_rst = 1'b1; tick();
        prog_rst = 1'b0; prog_en = 1'b0;
        check_tracks("mid_reset");
        rand_cfg(0); load(N);
        check_tracks("after_mid_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
